// File: rtl/key_evt_pkg.sv
// Shared definitions for the key event scheduler: channel state encodings and
// width helpers for event IDs and hold counters.
package key_evt_pkg;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StQual    = 3'd1;
  localparam logic [2:0] StPend    = 3'd2;
  localparam logic [2:0] StRelease = 3'd3;
  localparam logic [2:0] StLock    = 3'd4;

  function automatic int unsigned key_idw(input int unsigned n);
    return (n > 1) ? unsigned'($clog2(n)) : 1;
  endfunction

  function automatic int unsigned key_cntw(input int unsigned hold);
    return unsigned'($clog2(hold + 1));
  endfunction

endpackage

// File: rtl/key_qual_chan.sv
// One hold-qualification channel: counts consecutive request cycles, holds the
// qualified event until granted, then locks (one-shot) or waits for release.
module key_qual_chan
  import key_evt_pkg::*;
#(
  parameter int unsigned HOLD_CYC = 4,
  localparam int unsigned CW = key_cntw(HOLD_CYC)
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic oneshot,
  input  logic lock_clr,
  input  logic grant,
  output logic pend,
  output logic lock
);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (req) begin
          cnt_d   = CW'(1);
          state_d = (HOLD_CYC == 1) ? StPend : StQual;
        end
      end
      StQual: begin
        if (!req) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CW'(HOLD_CYC - 1)) begin
          state_d = StPend;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StPend: begin
        if (grant) state_d = oneshot ? StLock : StRelease;
      end
      StRelease: begin
        if (!req) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      StLock: begin
        // Unlock goes through RELEASE so a still-held key cannot re-fire.
        if (lock_clr) state_d = StRelease;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pend = (state_q == StPend);
  assign lock = (state_q == StLock);

endmodule

// File: rtl/key_event_scheduler.sv
// NCH hold-qualified key channels serialised by a round-robin arbiter onto a
// single valid/ready event port.
module key_event_scheduler
  import key_evt_pkg::*;
#(
  parameter int unsigned NCH = 4,
  parameter int unsigned HOLD_CYC = 4,
  localparam int unsigned IDW = key_idw(NCH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] key,
  input  logic [NCH-1:0] en,
  input  logic [NCH-1:0] cfg_oneshot,
  input  logic [NCH-1:0] lock_clr,
  output logic           evt_valid,
  output logic [IDW-1:0] evt_id,
  input  logic           evt_ready,
  output logic [NCH-1:0] pend_o,
  output logic [NCH-1:0] lock_o
);

  logic [NCH-1:0] req, grant;
  logic [IDW-1:0] ptr_q, win;
  logic [IDW-1:0] evt_id_q;
  logic           evt_valid_q;
  logic           slot_free, found;

  assign req       = key & en;
  assign slot_free = !evt_valid_q || evt_ready;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    key_qual_chan #(
      .HOLD_CYC(HOLD_CYC)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .req     (req[i]),
      .oneshot (cfg_oneshot[i]),
      .lock_clr(lock_clr[i]),
      .grant   (grant[i]),
      .pend    (pend_o[i]),
      .lock    (lock_o[i])
    );
  end

  // First pending channel after the last winner, wrapping modulo NCH.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      idx = (32'(ptr_q) + k) % NCH;
      if (!found && pend_o[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  always_comb begin
    grant = '0;
    if (slot_free && found) grant[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      ptr_q       <= IDW'(NCH - 1);
    end else if (slot_free) begin
      evt_valid_q <= found;
      if (found) begin
        evt_id_q <= win;
        ptr_q    <= win;
      end
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;

endmodule

// File: tb/tb_key_event_scheduler.sv
// Directed bench for key_event_scheduler: stimulus pushes expected event IDs,
// a negedge monitor pops them on each accepted handshake.
module tb_key_event_scheduler;

  localparam int unsigned NCH = 4;
  localparam int unsigned HOLD_CYC = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key, en, cfg_oneshot, lock_clr;
  logic       evt_valid, evt_ready;
  logic [1:0] evt_id;
  logic [3:0] pend_o, lock_o;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  key_event_scheduler #(
    .NCH     (NCH),
    .HOLD_CYC(HOLD_CYC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key        (key),
    .en         (en),
    .cfg_oneshot(cfg_oneshot),
    .lock_clr   (lock_clr),
    .evt_valid  (evt_valid),
    .evt_id     (evt_id),
    .evt_ready  (evt_ready),
    .pend_o     (pend_o),
    .lock_o     (lock_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every accepted event must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && evt_valid && evt_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got id %0d expected none at %0t", evt_id, $time);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (int'(evt_id) != e) begin
          errors++;
          $display("FAIL event_id: got %0d expected %0d at %0t", evt_id, e, $time);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; key = '0; en = 4'hF; cfg_oneshot = '0; lock_clr = '0; evt_ready = 1'b1;
    step(2);
    reset = 1'b0;
    check("rst_valid", evt_valid, 0);
    check("rst_id", evt_id, 0);
    check("rst_pend", pend_o, 0);
    check("rst_lock", lock_o, 0);

    // Basic qualification and single-cycle event
    key = 4'b0001;
    step(3);
    check("t1_not_yet", pend_o, 0);
    step(1);
    check("t1_pend", pend_o, 4'b0001);
    check("t1_valid_lat", evt_valid, 0);
    exp_q.push_back(0);
    step(1);
    check("t1_valid", evt_valid, 1);
    check("t1_id", evt_id, 0);
    check("t1_pend_clr", pend_o, 0);
    step(1);
    check("t1_one_cycle", evt_valid, 0);
    key = 4'b0000;
    step(1);
    key = 4'b0010;
    step(3);
    key = 4'b0000;
    step(3);
    check("t1_short_pend", pend_o, 0);
    check("t1_short_valid", evt_valid, 0);

    // One-shot lock
    cfg_oneshot = 4'b0010;
    key = 4'b0010;
    step(4);
    check("t2_pend", pend_o, 4'b0010);
    exp_q.push_back(1);
    step(6);
    check("t2_lock", lock_o, 4'b0010);
    key = 4'b0000;
    step(1);
    key = 4'b0010;
    step(6);
    check("t2_locked_pend", pend_o, 0);
    check("t2_locked_lock", lock_o, 4'b0010);
    check("t2_locked_valid", evt_valid, 0);
    lock_clr = 4'b0010;
    step(1);
    lock_clr = 4'b0000;
    key = 4'b0000;
    step(1);
    check("t2_unlocked", lock_o, 0);
    key = 4'b0010;
    step(4);
    check("t2_repend", pend_o, 4'b0010);
    exp_q.push_back(1);
    step(1);
    check("t2_revalid", evt_valid, 1);
    check("t2_reid", evt_id, 1);
    step(1);
    check("t2_relock", lock_o, 4'b0010);
    key = 4'b0000;
    lock_clr = 4'b0010;
    step(1);
    lock_clr = 4'b0000;
    step(1);
    check("t2_final_lock", lock_o, 0);
    cfg_oneshot = 4'b0000;

    // Auto re-arm and enable masking
    key = 4'b0100;
    step(4);
    check("t3_pend", pend_o, 4'b0100);
    exp_q.push_back(2);
    step(16);
    check("t3_hold_pend", pend_o, 0);
    check("t3_hold_lock", lock_o, 0);
    key = 4'b0000;
    step(1);
    key = 4'b0100;
    step(4);
    check("t3_repend", pend_o, 4'b0100);
    exp_q.push_back(2);
    step(2);
    key = 4'b0000;
    step(1);
    en = 4'b1011;
    key = 4'b0100;
    step(6);
    check("t3_en_pend", pend_o, 0);
    check("t3_en_valid", evt_valid, 0);
    key = 4'b0000;
    en = 4'hF;
    step(1);

    // Round robin from reset pointer
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    key = 4'b1111;
    step(4);
    check("t4_all_pend", pend_o, 4'b1111);
    for (int i = 0; i < 4; i++) exp_q.push_back(i);
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("t4_rr_valid", evt_valid, 1);
      check("t4_rr_id", evt_id, i);
    end
    key = 4'b0000;
    step(1);
    check("t4_drained", evt_valid, 0);
    key = 4'b1001;
    step(4);
    check("t4_pair_pend", pend_o, 4'b1001);
    exp_q.push_back(0);
    exp_q.push_back(3);
    step(1);
    check("t4_pair_first", evt_id, 0);
    step(1);
    check("t4_pair_second", evt_id, 3);
    key = 4'b0000;
    step(2);

    // Backpressure
    evt_ready = 1'b0;
    key = 4'b0100;
    step(4);
    exp_q.push_back(2);
    step(1);
    key = 4'b0101;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("t5_stall_valid", evt_valid, 1);
      check("t5_stall_id", evt_id, 2);
    end
    check("t5_ch0_pend", pend_o, 4'b0001);
    exp_q.push_back(0);
    evt_ready = 1'b1;
    step(1);
    check("t5_next_valid", evt_valid, 1);
    check("t5_next_id", evt_id, 0);
    step(1);
    check("t5_idle", evt_valid, 0);
    key = 4'b0000;
    step(2);

    // Reset in mid-operation
    evt_ready = 1'b0;
    key = 4'b0001;
    step(5);
    check("t6_pre_valid", evt_valid, 1);
    key = 4'b0011;
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    evt_ready = 1'b1;
    check("t6_rst_valid", evt_valid, 0);
    check("t6_rst_pend", pend_o, 0);
    check("t6_rst_lock", lock_o, 0);
    step(3);
    check("t6_requal_early", pend_o, 0);
    step(1);
    check("t6_requal", pend_o, 4'b0011);
    exp_q.push_back(0);
    exp_q.push_back(1);
    step(3);
    key = 4'b0000;
    step(2);
    check("scoreboard_drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
